// File: rtl/apb_req_bridge.sv
// apb_req_bridge: converts a word-wide req/gnt/rvalid data bus into single
// APB3 transfers, aborting with an error if PREADY stays low too long.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   data_req_i/gnt_o      request handshake (gnt only while idle)
//   data_we_i/addr_i/wdata_i  request payload
//   data_rvalid_o/rdata_o/err_o  one-cycle response, data/err held after
//   paddr_o..penable_o    APB master outputs
//   prdata_i/pready_i/pslverr_i  APB slave response
//   timeout_o             pulses with the response of a timed-out transfer
module apb_req_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 32'hBADCAB1E
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic                      timeout_o
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout_q, timeout_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             cnt_inc;
    logic                      to_hit;

    // Byte-lane bits are dropped: transfers are word-only.
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_addr_i[1:0];

    assign data_gnt_o    = (state_q == IDLE) & data_req_i;
    assign psel_o        = (state_q == SETUP) | (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign data_rvalid_o = (state_q == RESP);
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pwrite_o      = pwrite_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign timeout_o     = timeout_q;

    // cnt_inc counts the current ACCESS cycle, so the abort happens on the
    // TIMEOUT_CYCLES-th cycle without PREADY.
    assign cnt_inc = cnt_q + CW'(1);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    paddr_d  = {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwdata_d = data_wdata_i;
                    pwrite_d = data_we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_inc;
                end
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    state_d = RESP;
                end else if (to_hit) begin
                    rdata_d   = ERR_RDATA;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
